// File: rtl/s3_mux_reg_if.sv
// s3_mux_reg_if -- channel-side and consumer-side signals of the s3_mux_reg
// selector, bundled so the block and its environment share one port.
//
// Handshake semantics (apply to both sides of the block):
//   Output side: a word transfers on every rising edge where out_valid and
//   out_ready are both 1. out/out_ch stay stable while out_valid=1 and
//   out_ready=0.
//   Channel side: V[k] qualifies D[k]. The source holds V[k]/D[k] until it
//   sees ack[k]=1, and the word is taken on that edge. A source may drop
//   V[k] without an ack, and that word is then never captured.
//
// Signals:
//   D          channel data, channel k at [k*size +: size]
//   V          per-channel valid
//   sel        channel index used in direct mode
//   mode       0 = direct select, 1 = round-robin scan
//   out_ready  consumer accepts out this cycle
//   out        registered selected data
//   out_valid  out holds an unconsumed word
//   out_ch     source channel of out
//   ack        one-hot, channel captured at the coming edge
//   cnt        completed-transfer counter
//   out_par    parity of out (present only with S3_PARITY_EN)
//
// Modports: master = the selector block, slave = its environment.
// Optional feature macro: S3_PARITY_EN.
interface s3_mux_reg_if #(
   parameter int size = 5,
   parameter int CH   = 4
);
   localparam int SW = $clog2(CH);

   logic [CH*size-1:0] D;
   logic [CH-1:0]      V;
   logic [SW-1:0]      sel;
   logic               mode;
   logic               out_ready;
   logic [size-1:0]    out;
   logic               out_valid;
   logic [SW-1:0]      out_ch;
   logic [CH-1:0]      ack;
   logic [15:0]        cnt;
`ifdef S3_PARITY_EN
   logic               out_par;
`endif

   modport master (
      input  D, V, sel, mode, out_ready,
`ifdef S3_PARITY_EN
      output out_par,
`endif
      output out, out_valid, out_ch, ack, cnt
   );

   modport slave (
      output D, V, sel, mode, out_ready,
`ifdef S3_PARITY_EN
      input  out_par,
`endif
      input  out, out_valid, out_ch, ack, cnt
   );
endinterface

// File: rtl/s3_mux_reg.sv
// s3_mux_reg -- registered N:1 channel selector with valid/ready output.
//
// Picks one of CH channels, either directly by sel (mode=0) or by a
// round-robin scan starting at an internal pointer (mode=1), and captures
// it into a single output register. The captured channel gets a one-hot
// combinational ack in the cycle before the capturing edge.
//
// Ports:
//   clk    rising-edge clock
//   CLR_n  asynchronous active-low reset
//   bus    s3_mux_reg_if.master (D, V, sel, mode, out_ready in;
//          out, out_valid, out_ch, ack, cnt [, out_par] out)
//
// Optional feature macro: S3_PARITY_EN adds out_par = ^out, registered with out.
module s3_mux_reg #(
   parameter int size = 5,
   parameter int CH   = 4
) (
   input  logic          clk,
   input  logic          CLR_n,
   s3_mux_reg_if.master  bus
);
   localparam int SW = $clog2(CH);

   logic [SW-1:0]   ptr;
   logic            free;
   logic            cand_ok;
   logic [SW-1:0]   cand;
   logic [SW-1:0]   idx;
   logic            load;
   logic [size-1:0] cand_data;

   // The output slot can take a new word if it is empty or being drained now.
   assign free = !bus.out_valid || bus.out_ready;

   // Candidate selection. The round-robin scan walks offsets from the highest
   // down so that the lowest offset from ptr is the last (winning) assignment.
   // CH is a power of two, so the SW-bit add wraps modulo CH by itself.
   always_comb begin
      cand_ok = 1'b0;
      cand    = '0;
      idx     = '0;
      if (!bus.mode) begin
         cand    = bus.sel;
         cand_ok = bus.V[bus.sel];
      end else begin
         for (int i = CH - 1; i >= 0; i--) begin
            idx = ptr + SW'(i);
            if (bus.V[idx]) begin
               cand_ok = 1'b1;
               cand    = idx;
            end
         end
      end
   end

   assign load      = free && cand_ok;
   assign cand_data = bus.D[int'(cand)*size +: size];

   // ack is gated by CLR_n so that it drops immediately while reset is held.
   always_comb begin
      bus.ack = '0;
      if (load && CLR_n)
         bus.ack[cand] = 1'b1;
   end

   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n) begin
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_ch    <= '0;
         ptr           <= '0;
      end else if (free) begin
         if (cand_ok) begin
            bus.out       <= cand_data;
            bus.out_ch    <= cand;
            bus.out_valid <= 1'b1;
            if (bus.mode)
               ptr <= cand + SW'(1);
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n)
         bus.cnt <= '0;
      else if (bus.out_valid && bus.out_ready)
         bus.cnt <= bus.cnt + 16'd1;
   end

`ifdef S3_PARITY_EN
   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n)
         bus.out_par <= 1'b0;
      else if (load)
         bus.out_par <= ^cand_data;
   end
`endif

endmodule

// File: tb/tb_s3_mux_reg.sv
// tb_s3_mux_reg -- directed self-checking bench for s3_mux_reg (size=5, CH=4).
module tb_s3_mux_reg;
   logic clk;
   logic CLR_n;
   int   checks;
   int   failures;

   s3_mux_reg_if #(.size(5), .CH(4)) bus ();

   s3_mux_reg #(.size(5), .CH(4)) dut (
      .clk   (clk),
      .CLR_n (CLR_n),
      .bus   (bus)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [4:0] d0, input logic [4:0] d1,
                        input logic [4:0] d2, input logic [4:0] d3);
      bus.D = {d3, d2, d1, d0};
   endtask

   task automatic apply_reset();
      CLR_n = 1'b0;
      #2;
      CLR_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.mode = 1'b0; bus.sel = 2'd1; bus.V = 4'b0010; bus.out_ready = 1'b0;
      set_d(5'h00, 5'h1A, 5'h00, 5'h00);
      step();
      checks++;
      if (bus.out !== 5'h1A || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_preload out=%h valid=%b exp out=1a valid=1", bus.out, bus.out_valid);
      end
      step();
      #3;
      CLR_n = 1'b0;
      #1;
      checks++;
      if (bus.out !== 5'h00 || bus.out_valid !== 1'b0 || bus.out_ch !== 2'd0 ||
          bus.cnt !== 16'd0 || bus.ack !== 4'b0000) begin
         failures++;
         $display("FAIL reset_async out=%h valid=%b ch=%0d cnt=%0d ack=%b exp all zero",
                  bus.out, bus.out_valid, bus.out_ch, bus.cnt, bus.ack);
      end
      #1;
      CLR_n = 1'b1;
      bus.mode = 1'b1; bus.V = 4'b1111; bus.out_ready = 1'b1;
      set_d(5'h10, 5'h11, 5'h12, 5'h13);
      #1;
      checks++;
      if (bus.ack !== 4'b0001) begin
         failures++;
         $display("FAIL reset_release_ack ack=%b exp 0001", bus.ack);
      end
      step();
      checks++;
      if (bus.out_ch !== 2'd0 || bus.out !== 5'h10 || bus.out_valid !== 1'b1 || bus.cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_first_load ch=%0d out=%h valid=%b cnt=%0d exp ch=0 out=10 valid=1 cnt=0",
                  bus.out_ch, bus.out, bus.out_valid, bus.cnt);
      end
   endtask

   task automatic test_direct();
      bus.mode = 1'b0; bus.sel = 2'd2; bus.V = 4'b0100; bus.out_ready = 1'b1;
      set_d(5'h00, 5'h00, 5'h15, 5'h00);
      #1;
      checks++;
      if (bus.ack !== 4'b0100) begin
         failures++;
         $display("FAIL direct_ack ack=%b exp 0100", bus.ack);
      end
      step();
      checks++;
      if (bus.out !== 5'h15 || bus.out_ch !== 2'd2 || bus.out_valid !== 1'b1 || bus.cnt !== 16'd1) begin
         failures++;
         $display("FAIL direct_load out=%h ch=%0d valid=%b cnt=%0d exp out=15 ch=2 valid=1 cnt=1",
                  bus.out, bus.out_ch, bus.out_valid, bus.cnt);
      end
`ifdef S3_PARITY_EN
      checks++;
      if (bus.out_par !== 1'b1) begin
         failures++;
         $display("FAIL direct_parity par=%b exp 1", bus.out_par);
      end
`endif
   endtask

   task automatic test_direct_invalid();
      bus.sel = 2'd1; bus.V = 4'b1101;
      #1;
      checks++;
      if (bus.ack !== 4'b0000) begin
         failures++;
         $display("FAIL direct_invalid_ack ack=%b exp 0000", bus.ack);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== 5'h15 || bus.out_ch !== 2'd2 || bus.cnt !== 16'd2) begin
         failures++;
         $display("FAIL direct_invalid out=%h ch=%0d valid=%b cnt=%0d exp out=15 ch=2 valid=0 cnt=2",
                  bus.out, bus.out_ch, bus.out_valid, bus.cnt);
      end
   endtask

   task automatic test_rr_fairness();
      logic [1:0] exp_ch;
      logic [3:0] exp_ack;
      apply_reset();
      bus.mode = 1'b1; bus.V = 4'b1111; bus.out_ready = 1'b1;
      set_d(5'h10, 5'h11, 5'h12, 5'h13);
      #1;
      for (int i = 0; i < 6; i++) begin
         exp_ch  = 2'(i % 4);
         exp_ack = 4'b0001 << exp_ch;
         checks++;
         if (bus.ack !== exp_ack) begin
            failures++;
            $display("FAIL rr_fair_ack[%0d] ack=%b exp %b", i, bus.ack, exp_ack);
         end
         step();
         checks++;
         if (bus.out_ch !== exp_ch || bus.out !== (5'h10 + 5'(exp_ch)) || bus.cnt !== 16'(i)) begin
            failures++;
            $display("FAIL rr_fair[%0d] ch=%0d out=%h cnt=%0d exp ch=%0d out=%h cnt=%0d",
                     i, bus.out_ch, bus.out, bus.cnt, exp_ch, 5'h10 + 5'(exp_ch), i);
         end
      end
   endtask

   task automatic test_rr_skip_wrap();
      logic [3:0] v_vec   [4];
      logic [3:0] ack_vec [4];
      logic [1:0] ch_vec  [4];
      v_vec   = '{4'b0100, 4'b0110, 4'b0001, 4'b0101};
      ack_vec = '{4'b0100, 4'b0010, 4'b0001, 4'b0100};
      ch_vec  = '{2'd2,    2'd1,    2'd0,    2'd2};
      // ptr starts at 2; first vector moves it to 3 for the wrap case.
      for (int i = 0; i < 4; i++) begin
         bus.V = v_vec[i];
         #1;
         checks++;
         if (bus.ack !== ack_vec[i]) begin
            failures++;
            $display("FAIL rr_skip_ack[%0d] ack=%b exp %b", i, bus.ack, ack_vec[i]);
         end
         step();
         checks++;
         if (bus.out_ch !== ch_vec[i] || bus.out !== (5'h10 + 5'(ch_vec[i])) || bus.cnt !== 16'(6 + i)) begin
            failures++;
            $display("FAIL rr_skip[%0d] ch=%0d out=%h cnt=%0d exp ch=%0d out=%h cnt=%0d",
                     i, bus.out_ch, bus.out, bus.cnt, ch_vec[i], 5'h10 + 5'(ch_vec[i]), 6 + i);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] v_vec [3];
      v_vec = '{4'b1111, 4'b0011, 4'b1001};
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.V = v_vec[i];
         set_d(5'(i + 1), 5'(i + 5), 5'(i + 9), 5'(i + 13));
         #1;
         checks++;
         if (bus.ack !== 4'b0000) begin
            failures++;
            $display("FAIL bp_ack[%0d] ack=%b exp 0000", i, bus.ack);
         end
         step();
         checks++;
         if (bus.out !== 5'h12 || bus.out_ch !== 2'd2 || bus.out_valid !== 1'b1 || bus.cnt !== 16'd9) begin
            failures++;
            $display("FAIL bp_hold[%0d] out=%h ch=%0d valid=%b cnt=%0d exp out=12 ch=2 valid=1 cnt=9",
                     i, bus.out, bus.out_ch, bus.out_valid, bus.cnt);
         end
      end
      bus.out_ready = 1'b1; bus.V = 4'b1000;
      set_d(5'h00, 5'h00, 5'h00, 5'h0C);
      #1;
      checks++;
      if (bus.ack !== 4'b1000) begin
         failures++;
         $display("FAIL bp_release_ack ack=%b exp 1000", bus.ack);
      end
      step();
      checks++;
      if (bus.out !== 5'h0C || bus.out_ch !== 2'd3 || bus.out_valid !== 1'b1 || bus.cnt !== 16'd10) begin
         failures++;
         $display("FAIL bp_release out=%h ch=%0d valid=%b cnt=%0d exp out=0c ch=3 valid=1 cnt=10",
                  bus.out, bus.out_ch, bus.out_valid, bus.cnt);
      end
      bus.V = 4'b0000;
      #1;
      checks++;
      if (bus.ack !== 4'b0000) begin
         failures++;
         $display("FAIL drain_ack ack=%b exp 0000", bus.ack);
      end
      step();
      checks++;
      if (bus.out !== 5'h0C || bus.out_ch !== 2'd3 || bus.out_valid !== 1'b0 || bus.cnt !== 16'd11) begin
         failures++;
         $display("FAIL drain out=%h ch=%0d valid=%b cnt=%0d exp out=0c ch=3 valid=0 cnt=11",
                  bus.out, bus.out_ch, bus.out_valid, bus.cnt);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cnt !== 16'd11) begin
         failures++;
         $display("FAIL idle_cnt valid=%b cnt=%0d exp valid=0 cnt=11", bus.out_valid, bus.cnt);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      CLR_n     = 1'b0;
      bus.D     = '0;
      bus.V     = '0;
      bus.sel   = '0;
      bus.mode  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.out !== 5'h00 || bus.out_valid !== 1'b0 || bus.out_ch !== 2'd0 ||
          bus.cnt !== 16'd0 || bus.ack !== 4'b0000) begin
         failures++;
         $display("FAIL initial_reset out=%h valid=%b ch=%0d cnt=%0d ack=%b exp all zero",
                  bus.out, bus.out_valid, bus.out_ch, bus.cnt, bus.ack);
      end
      #12;
      CLR_n = 1'b1;
      test_reset();
      test_direct();
      test_direct_invalid();
      test_rr_fairness();
      test_rr_skip_wrap();
      test_backpressure();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
